// File: rtl/adder_byte_feeder_pkg.sv
// Shared types and constants for the byte-serial operand feeder.
package adder_feed_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_IN_W   = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        OUT     = 2'd3
    } feed_state_e;

    // Number of input beats needed to fill one operand word.
    function automatic int calcBeats(input int dataW, input int inW);
        return dataW / inW;
    endfunction

    // Beat counter width; a single-beat word still gets a 1-bit counter.
    function automatic int calcCntW(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain combinational 32-bit adder; it exposes no carry-out.
module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_byte_feeder_beat_word_assembler.sv
// Builds one DATA_W word from IN_W beats, least-significant beat first.
module beat_word_assembler
    import adder_feed_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IN_W   = DEFAULT_IN_W
) (
    input  logic              clk,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [IN_W-1:0]   beat_i,
    output logic [DATA_W-1:0] word_o,
    output logic              last_beat_o,
    output logic              count_zero_o
);

    localparam int BEATS = calcBeats(DATA_W, IN_W);
    localparam int CNT_W = calcCntW(BEATS);

    logic [CNT_W-1:0]  beatCnt_q;
    logic [DATA_W-1:0] word_q;

    assign last_beat_o  = (beatCnt_q == CNT_W'(BEATS - 1));
    assign count_zero_o = (beatCnt_q == '0);
    assign word_o       = word_q;

    // Clear wipes the word and restarts the count; a load drops the beat into its slice.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            beatCnt_q <= '0;
            word_q    <= '0;
        end else if (load_i) begin
            word_q[beatCnt_q*IN_W +: IN_W] <= beat_i;
            beatCnt_q <= last_beat_o ? '0 : beatCnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/adder_byte_feeder.sv
// Byte-serial operand feeder: loads a then b, captures the adder sum, and
// holds the result on a valid/ready port until it is taken.
module adder_byte_feeder
    import adder_feed_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IN_W   = DEFAULT_IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_sum,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    feed_state_e       state_q;
    logic [DATA_W-1:0] outSum_q;
    logic              outCarry_q;
    logic              outValid_q;

    logic loadA;
    logic loadB;
    logic lastA;
    logic lastB;
    logic zeroA;
    logic zeroB;

    // Beats are only taken while loading, and never while reset is asserted.
    assign in_ready = !rst && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign loadA    = in_valid && in_ready && (state_q == LOAD_A);
    assign loadB    = in_valid && in_ready && (state_q == LOAD_B);
    assign busy     = !((state_q == LOAD_A) && zeroA);

    assign out_sum   = outSum_q;
    assign out_carry = outCarry_q;
    assign out_valid = outValid_q;

    beat_word_assembler #(.DATA_W(DATA_W), .IN_W(IN_W)) u_asmA (
        .clk          (clk),
        .clear_i      (rst),
        .load_i       (loadA),
        .beat_i       (in_data),
        .word_o       (add_a),
        .last_beat_o  (lastA),
        .count_zero_o (zeroA)
    );

    beat_word_assembler #(.DATA_W(DATA_W), .IN_W(IN_W)) u_asmB (
        .clk          (clk),
        .clear_i      (rst),
        .load_i       (loadB),
        .beat_i       (in_data),
        .word_o       (add_b),
        .last_beat_o  (lastB),
        .count_zero_o (zeroB)
    );

    // Sequencer plus result registers; carry is recovered as "sum wrapped below a".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD_A;
            outSum_q   <= '0;
            outCarry_q <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (loadA && lastA) begin
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (loadB && lastB) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    outSum_q   <= add_sum;
                    outCarry_q <= (add_sum < add_a);
                    outValid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (outValid_q && out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= LOAD_A;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    // zeroB is only a by-product of the shared assembler; fold it in harmlessly.
    logic unusedZeroB;
    assign unusedZeroB = zeroB;

endmodule

// File: tb/tb_adder_byte_feeder.sv
// Bench for adder_byte_feeder wired to adder_32bit, with a result scoreboard.
module tb_adder_byte_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
    } exp_t;

    exp_t expQ[$];
    int   hsCycles[$];
    int   hsCount      = 0;
    int   riseCycle    = -1;
    int   lastBeatEdge = 0;
    int   cycle        = 0;
    int   errors       = 0;
    int   checks       = 0;
    logic prevValid    = 1'b0;

    adder_byte_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    adder_32bit u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    // Free-running clock and edge counter used for latency/throughput checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    // Monitor: pops the scoreboard on every output handshake and records timing.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && prevValid !== 1'b1) riseCycle = cycle;
            prevValid = out_valid;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    failNow("unexpected_result");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_sum", out_sum, e.sum);
                    checkOutput("out_carry", 32'(out_carry), 32'(e.carry));
                end
                hsCycles.push_back(cycle);
                hsCount++;
            end
        end
    end

    task automatic sendBeat(input logic [7:0] b);
        int budget = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && budget < 100) begin
            budget++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) failNow("beat_timeout");
        @(posedge clk);
        #1;
        lastBeatEdge = cycle;
    endtask

    task automatic sendWord(input logic [31:0] w, input bit bubbles);
        for (int i = 0; i < 4; i++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            sendBeat(w[i*8 +: 8]);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expSum, input logic expCarry, input bit bubbles);
        exp_t e;
        sendWord(a, bubbles);
        sendWord(b, bubbles);
        e.sum   = expSum;
        e.carry = expCarry;
        expQ.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic waitResults(input int target);
        int budget = 0;
        while (hsCount < target && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (hsCount < target) failNow("result_timeout");
        #1;
    endtask

    // Watchdog so a stuck handshake still ends in a summary line.
    initial begin
        #200000;
        failNow("watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Directed scenario sequence.
    initial begin
        int budget;
        int edgeK;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_add_a", add_a, 32'd0);
        checkOutput("rst_add_b", add_b, 32'd0);
        checkOutput("rst_out_sum", out_sum, 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Basic addition and output latency.
        @(posedge clk);
        #1;
        applyStimulus(32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0);
        edgeK = lastBeatEdge;
        waitResults(1);
        checkOutput("t1_valid_latency", 32'(riseCycle), 32'(edgeK + 1));
        checkOutput("t1_add_a_held", add_a, 32'h00000001);
        checkOutput("t1_add_b_held", add_b, 32'h00000002);

        // Wrap-around cases.
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        applyStimulus(32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
        waitResults(3);

        // Backpressure: result must stay stable and input stalled.
        out_ready = 1'b0;
        applyStimulus(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);
        budget = 0;
        while (out_valid !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (out_valid !== 1'b1) failNow("t3_valid_timeout");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t3_valid_hold", 32'(out_valid), 32'd1);
            checkOutput("t3_sum_hold", out_sum, 32'h23456789);
            checkOutput("t3_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitResults(4);
        @(negedge clk);
        checkOutput("t3_in_ready_after", 32'(in_ready), 32'd1);
        checkOutput("t3_valid_after", 32'(out_valid), 32'd0);

        // Input bubbles between beats.
        @(posedge clk);
        #1;
        applyStimulus(32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b1);
        waitResults(5);

        // Reset in the middle of loading; the partial transaction must vanish.
        sendBeat(8'h11);
        sendBeat(8'h22);
        sendBeat(8'h33);
        sendBeat(8'h44);
        sendBeat(8'h55);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        checkOutput("t5_in_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_add_a", add_a, 32'd0);
        checkOutput("t5_add_b", add_b, 32'd0);
        checkOutput("t5_out_sum", out_sum, 32'd0);
        checkOutput("t5_out_carry", 32'(out_carry), 32'd0);
        checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h000000FF, 32'h00000F01, 32'h00001000, 1'b0, 1'b0);
        waitResults(6);

        // Back-to-back throughput with continuous input and out_ready high.
        applyStimulus(32'hDEADBEEF, 32'h21524111, 32'h00000000, 1'b1, 1'b0);
        applyStimulus(32'h0000FFFF, 32'h00010001, 32'h00020000, 1'b0, 1'b0);
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
        waitResults(9);
        if (hsCycles.size() >= 9) begin
            checkOutput("t6_period_1", 32'(hsCycles[7] - hsCycles[6]), 32'd10);
            checkOutput("t6_period_2", 32'(hsCycles[8] - hsCycles[7]), 32'd10);
        end else begin
            failNow("t6_handshake_count");
        end

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
